// File: rtl/demux_pkg.sv
// demux_pkg: shared sizes for demux8_wb (slot count, select width, write-counter width)
package demux_pkg;
  localparam int SLOTS = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 16;
endpackage

// File: rtl/demux8_wb_if.sv
// demux8_wb_if: write/slot bus for demux8_wb; master drives in_valid/in_data/in_sel/out_ack, slave drives in_ready/out_data/out_valid/wr_count
interface demux8_wb_if import demux_pkg::*; #(parameter int WIDTH = 32);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic [SLOTS*WIDTH-1:0] out_data;
  logic [SLOTS-1:0]       out_valid;
  logic [SLOTS-1:0]       out_ack;
  logic [CNT_W-1:0]       wr_count;
  modport master (output in_valid, in_data, in_sel, out_ack, input in_ready, out_data, out_valid, wr_count);
  modport slave (input in_valid, in_data, in_sel, out_ack, output in_ready, out_data, out_valid, wr_count);
endinterface

// File: rtl/demux8_wb_decoder.sv
// decoder3to8: one-hot slot write enables from i_sel, all zero unless i_en is set
module decoder3to8 import demux_pkg::*; (
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [SLOTS-1:0] o_we
);
  assign o_we = i_en ? (SLOTS'(1) << i_sel) : '0;
endmodule

// File: rtl/demux8_wb.sv
// demux8_wb: 8-slot write demux with per-slot valid/ack and saturating write count; ports clk, reset, bus (demux8_wb_if.slave); DEMUX8_WB_NO_OVERWRITE_EN back-pressures writes to occupied slots
module demux8_wb import demux_pkg::*; #(parameter int WIDTH = 32) (
  input logic        clk,
  input logic        reset,
  demux8_wb_if.slave bus
);
  logic [SLOTS-1:0][WIDTH-1:0] r_data;
  logic [SLOTS-1:0]            r_valid;
  logic [CNT_W-1:0]            r_cnt;
  logic                        w_acc;
  logic [SLOTS-1:0]            w_we;
`ifdef DEMUX8_WB_NO_OVERWRITE_EN
  assign bus.in_ready = !reset && (!r_valid[bus.in_sel] || bus.out_ack[bus.in_sel]);
`else
  assign bus.in_ready = !reset;
`endif
  assign w_acc = bus.in_valid && bus.in_ready;
  decoder3to8 u_dec (.i_sel(bus.in_sel), .i_en(w_acc), .o_we(w_we));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= '0;
      r_cnt   <= '0;
    end else begin
      for (int k = 0; k < SLOTS; k++)
        if (w_we[k]) r_data[k] <= bus.in_data;
      r_valid <= (r_valid & ~bus.out_ack) | w_we;
      if (w_acc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.wr_count  = r_cnt;
endmodule

// File: tb/tb_demux8_wb.sv
// tb_demux8_wb: self-checking bench for demux8_wb (vector table + scoreboard + corner sequences)
module tb_demux8_wb;
  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [31:0] d;
    logic [7:0]  ack;
    logic [7:0]  ev;
    logic [15:0] ec;
    logic [31:0] es;
  } vec_t;
  logic clk = 0;
  logic reset = 1;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[9];
  vec_t sb[$];
  logic [255:0] e0;
  always #5 clk = ~clk;
  demux8_wb_if #(.WIDTH(32)) bus();
  demux8_wb #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] d, input logic [7:0] a);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
    bus.out_ack  = a;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1;
    drive(0, 0, 0, 0);
    step;
    reset = 0;
  endtask
  function automatic logic [31:0] slot(input int k);
    logic [255:0] od;
    od = bus.out_data;
    return od[k*32 +: 32];
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{1, 3, 32'hDEADBEEF, 8'h00, 8'h08, 16'd1, 32'hDEADBEEF};
    tbl[1] = '{1, 5, 32'h00000055, 8'h00, 8'h28, 16'd2, 32'h00000055};
    tbl[2] = '{0, 5, 32'h00000000, 8'h20, 8'h08, 16'd2, 32'h00000055};
    tbl[3] = '{1, 5, 32'h00000066, 8'h20, 8'h28, 16'd3, 32'h00000066};
    tbl[4] = '{1, 0, 32'h00000001, 8'h08, 8'h21, 16'd4, 32'h00000001};
    tbl[5] = '{0, 0, 32'h00000000, 8'h80, 8'h21, 16'd4, 32'h00000001};
    tbl[6] = '{1, 0, 32'h00000002, 8'h21, 8'h01, 16'd5, 32'h00000002};
    tbl[7] = '{1, 7, 32'h0000A5A5, 8'h00, 8'h81, 16'd6, 32'h0000A5A5};
    tbl[8] = '{1, 2, 32'h00000022, 8'h81, 8'h04, 16'd7, 32'h00000022};
    drive(1, 2, 32'h55, 8'hFF);
    reset = 1;
    step;
    step;
    chk("rst_valid", bus.out_valid, 8'h00);
    chk("rst_data", bus.out_data, 0);
    chk("rst_cnt", bus.wr_count, 0);
    chk("rst_ready", bus.in_ready, 0);
    reset = 0;
    drive(0, 0, 0, 0);
    #1;
    chk("ready_idle", bus.in_ready, 1);
    for (int i = 0; i < 9; i++) begin
      vec_t e;
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ack);
      sb.push_back(tbl[i]);
      step;
      e = sb.pop_front();
      chk($sformatf("vec%0d_valid", i), bus.out_valid, e.ev);
      chk($sformatf("vec%0d_cnt", i), bus.wr_count, e.ec);
      chk($sformatf("vec%0d_slot", i), slot(int'(e.sel)), e.es);
      if (i == 0) begin
        e0 = '0;
        e0[127:96] = 32'hDEADBEEF;
        chk("basic_all_slots", bus.out_data, e0);
      end
    end
`ifdef DEMUX8_WB_NO_OVERWRITE_EN
    do_reset;
    drive(1, 0, 32'h1, 0);
    step;
    chk("bp_first_valid", bus.out_valid, 8'h01);
    drive(1, 0, 32'h7, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp_ready%0d", c), bus.in_ready, 0);
      step;
      chk($sformatf("bp_hold%0d", c), slot(0), 32'h1);
    end
    chk("bp_hold_cnt", bus.wr_count, 1);
    bus.out_ack = 8'h01;
    #1;
    chk("bp_ack_ready", bus.in_ready, 1);
    step;
    drive(0, 0, 0, 0);
    chk("bp_slot0", slot(0), 32'h7);
    chk("bp_valid", bus.out_valid, 8'h01);
    chk("bp_cnt", bus.wr_count, 2);
`else
    do_reset;
    drive(1, 0, 32'h1, 0);
    #1;
    chk("ow_ready1", bus.in_ready, 1);
    step;
    drive(1, 0, 32'h2, 0);
    #1;
    chk("ow_ready2", bus.in_ready, 1);
    step;
    drive(0, 0, 0, 0);
    chk("ow_slot0", slot(0), 32'h2);
    chk("ow_cnt", bus.wr_count, 2);
    chk("ow_valid", bus.out_valid, 8'h01);
`endif
    do_reset;
    for (int k = 1; k < 5; k++) begin
      drive(1, k[2:0], 32'h100 + k, 0);
      step;
    end
    chk("mid_pre_valid", bus.out_valid, 8'h1E);
    drive(1, 6, 32'h99, 0);
    reset = 1;
    #1;
    chk("mid_ready_in_rst", bus.in_ready, 0);
    step;
    chk("mid_valid", bus.out_valid, 8'h00);
    chk("mid_data", bus.out_data, 0);
    chk("mid_cnt", bus.wr_count, 0);
    chk("mid_ready", bus.in_ready, 0);
    reset = 0;
    drive(1, 6, 32'h77, 0);
    step;
    drive(0, 0, 0, 0);
    chk("post_valid", bus.out_valid, 8'h40);
    chk("post_slot6", slot(6), 32'h77);
    chk("post_cnt", bus.wr_count, 1);
    do_reset;
    drive(1, 1, 32'hABC, 8'hFF);
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_full", bus.wr_count, 16'hFFFF);
    step;
    chk("sat_hold", bus.wr_count, 16'hFFFF);
    drive(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
